comparator_operand_loader: RTL
==============================

// Module: comparator_operand_loader
// PURPOSE
//  Serial-to-parallel front end for the multi-bit comparator. Receives operands a and b as two
//  synchronous MSB-first bit streams, one bit of each per accepted beat. Assembles n+1-bit words
//  and presents them as a parallel pair with a valid/ready handshake, ready to drive a_in/b_in.
//  Frames are delimited by a start-of-frame flag. Malformed framing is reported, not propagated.
// PARAMETERS
//  n  3  operand MSB index; operand width is n+1 bits (n >= 1)
// PORTS
//  clk        in   1    single clock; all logic on posedge
//  reset      in   1    synchronous, active-low reset
//  ser_valid  in   1    serial beat valid
//  ser_ready  out  1    loader can accept a serial beat
//  ser_sof    in   1    beat carries the MSB (first bit) of a new frame
//  ser_a      in   1    current bit of operand a
//  ser_b      in   1    current bit of operand b
//  op_valid   out  1    a_out/b_out hold a complete operand pair
//  op_ready   in   1    downstream accepts the pair
//  a_out      out  n+1  assembled operand a (first received bit in a_out[n])
//  b_out      out  n+1  assembled operand b
//  frame_err  out  1    one-cycle registered pulse on a framing error
// BEHAVIOUR
//  - Beat = ser_valid & ser_ready at posedge. Handoff = op_valid & op_ready at posedge.
//  - Reset (reset==0 at posedge): state=IDLE, shift regs=0, bit count=0, a_out=b_out=0,
//    op_valid=0, frame_err=0. ser_ready is forced 0 while reset is low.
//  - Reset at any time aborts a partial frame and discards a held pair. No op_valid follows.
//  - ser_ready = reset & (state != HOLD). It is combinational from state.
//  - Bit count is clog2(n+2) bits wide. It counts accepted bits of the current frame.
//  - IDLE:
//    - Beat with sof=1 loads {ser_a,ser_b} into the LSBs, sets count=1, and goes to SHIFT.
//    - Beat with sof=0 drops the bits, pulses frame_err next cycle, and stays in IDLE.
//  - SHIFT:
//    - Beat with sof=0 does a_sh <= {a_sh[n-1:0],ser_a} (same for b) and count+1.
//    - The beat that makes count==n+1 moves to HOLD. On that edge a_out/b_out get the
//      completed words and op_valid=1, so the pair is visible the cycle after the last beat.
//    - Beat with sof=1 restarts the frame: that bit becomes the first bit, count=1, and
//      frame_err pulses. The partial frame is discarded.
//    - Cycles without a beat hold all state (gaps allowed).
//  - HOLD:
//    - op_valid=1; a_out/b_out stay stable until the handoff. ser_valid is ignored.
//    - On handoff: op_valid=0, count=0, state=IDLE next cycle. a_out/b_out keep their last
//      values.
//  - Throughput: at most one pair per n+2 cycles (n+1 beats plus 1 handoff cycle).
//  - frame_err is never asserted for two cycles due to one event. Each error is its own pulse.
// TESTING (n=3)
//  1. Reset low 2 cycles, release; 4 back-to-back beats (sof on 1st), a=1,0,1,1 b=1,0,0,1
//     -> op_valid=1 the cycle after beat 4, a_out=4'hB, b_out=4'h9, frame_err=0 throughout.
//  2. After test 1, hold op_ready=0 for 5 cycles with ser_valid=1
//     -> ser_ready=0, outputs stable 4'hB/4'h9. Then op_ready=1 for 1 cycle
//     -> op_valid=0 and ser_ready=1 next cycle.
//  3. Same frame as test 1 with 2 idle cycles between each beat -> identical a_out/b_out.
//  4. sof, 2 beats (a=1,1), then sof again followed by a=0,1,1,0 (b=0)
//     -> one frame_err pulse on the restart, then a_out=4'h6, b_out=4'h0.
//  5. In IDLE, beat with sof=0 -> frame_err pulse, no op_valid, next sof frame loads correctly.
//  6. Reset low after 3 beats, and again while in HOLD -> op_valid=0, a_out=b_out=0, and the
//     next full frame is assembled correctly.

Source files
------------

// File: rtl/comparator_operand_loader.sv
// Serial-to-parallel operand loader: assembles two MSB-first bit streams into n+1-bit words
// and hands them to the comparator with a valid/ready handshake.
module comparator_operand_loader #(
    parameter int n = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_valid,
    output logic       ser_ready,
    input  logic       ser_sof,
    input  logic       ser_a,
    input  logic       ser_b,
    output logic       op_valid,
    input  logic       op_ready,
    output logic [n:0] a_out,
    output logic [n:0] b_out,
    output logic       frame_err
);

    localparam int CW = $clog2(n + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(n);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [n:0]    a_sh;
    logic [n:0]    b_sh;
    logic [CW-1:0] count;
    logic          beat;
    logic [n:0]    a_next;
    logic [n:0]    b_next;

    assign ser_ready = reset & (state != HOLD);
    assign beat      = ser_valid & ser_ready;
    assign a_next    = {a_sh[n-1:0], ser_a};
    assign b_next    = {b_sh[n-1:0], ser_b};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            count     <= '0;
            a_out     <= '0;
            b_out     <= '0;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (ser_sof) begin
                            a_sh  <= {{n{1'b0}}, ser_a};
                            b_sh  <= {{n{1'b0}}, ser_b};
                            count <= CW'(1);
                            state <= SHIFT;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        if (ser_sof) begin
                            // Restart: the sof bit becomes the first bit of a fresh frame
                            a_sh      <= {{n{1'b0}}, ser_a};
                            b_sh      <= {{n{1'b0}}, ser_b};
                            count     <= CW'(1);
                            frame_err <= 1'b1;
                        end else begin
                            a_sh  <= a_next;
                            b_sh  <= b_next;
                            count <= count + CW'(1);
                            if (count == LAST_IDX) begin
                                a_out    <= a_next;
                                b_out    <= b_next;
                                op_valid <= 1'b1;
                                state    <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        count    <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_valid <= 1'b0;
                    count    <= '0;
                end
            endcase
        end
    end

endmodule
